mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe_if.sv | 27 ++
 rtl/mux_n_pipe.sv | 90 +++++++++
 tb/tb_mux_n_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_pipe_if.sv
// Channel bundle between the upstream sources / downstream sink and mux_n_pipe.
interface mux_n_pipe_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
);
  logic              mode;
  logic [SW-1:0]     ctrl;
  logic [N*W-1:0]    D;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic              out_ready;
  logic [W-1:0]      S;
  logic              out_valid;
  logic [SW-1:0]     out_ch;
  logic              sel_err;

  modport master (
    output mode, ctrl, D, in_valid, out_ready,
    input  in_ready, S, out_valid, out_ch, sel_err
  );

  modport slave (
    input  mode, ctrl, D, in_valid, out_ready,
    output in_ready, S, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N-channel multiplexer with a single registered output slot.
// Direct mode selects the channel given by ctrl; round-robin mode scans
// from an internal pointer and advances past each channel it serves.
module mux_n_pipe #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic         clk,
  input  logic         rst,
  mux_n_pipe_if.slave  bus
);

  logic [W-1:0]  chan [N];
  logic [SW-1:0] p;
  logic [SW-1:0] rr_grant;
  logic [SW-1:0] grant;
  logic [SW-1:0] p_next;
  logic [N-1:0]  rot;
  logic [31:0]   rr_off;
  logic [31:0]   rr_sum;
  logic          rr_hit;
  logic          dir_hit;
  logic          ctrl_ok;
  logic          hit;
  logic          slot_free;
  logic          xfer;

  // Unpack the flattened data bus into per-channel words.
  for (genvar k = 0; k < int'(N); k++) begin : g_chan
    assign chan[k] = bus.D[k*W +: W];
  end

  // Direct-mode decode: range check on ctrl and valid of the addressed channel.
  always_comb begin
    ctrl_ok = 32'(bus.ctrl) < N;
    dir_hit = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.ctrl == SW'(k) && bus.in_valid[SW'(k)]) dir_hit = 1'b1;
    end
  end

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the first set bit.
  always_comb begin
    rot    = N'({bus.in_valid, bus.in_valid} >> p);
    rr_hit = 1'b0;
    rr_off = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!rr_hit && rot[SW'(i)]) begin
        rr_hit = 1'b1;
        rr_off = i;
      end
    end
    rr_sum = 32'(p) + rr_off;
    if (rr_sum >= N) rr_sum = rr_sum - N;
    rr_grant = SW'(rr_sum);
  end

  // Grant selection, handshake strobes and the pointer successor.
  always_comb begin
    grant        = bus.mode ? rr_grant : bus.ctrl;
    hit          = bus.mode ? rr_hit : (ctrl_ok && dir_hit);
    slot_free    = !bus.out_valid || bus.out_ready;
    xfer         = !rst && slot_free && hit;
    bus.sel_err  = !rst && !bus.mode && slot_free && !ctrl_ok;
    bus.in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.in_ready[SW'(k)] = xfer && (grant == SW'(k));
    end
    p_next = (32'(grant) == N - 1) ? '0 : grant + SW'(1);
  end

  // Output slot and round-robin pointer; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.S         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      p             <= '0;
    end else if (xfer) begin
      bus.S         <= chan[grant];
      bus.out_ch    <= grant;
      bus.out_valid <= 1'b1;
      if (bus.mode) p <= p_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-channel instance and a 3-channel instance.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.W(32), .N(4), .SW(2)) bus4 ();
  mux_n_pipe_if #(.W(32), .N(3), .SW(2)) bus3 ();

  mux_n_pipe #(.W(32), .N(4), .SW(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_n_pipe #(.W(32), .N(3), .SW(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] d4(input int k);
    case (k)
      0:       return 32'hA5A5_0000;
      1:       return 32'h0000_0011;
      2:       return 32'hA5A5_0002;
      default: return 32'h0000_0033;
    endcase
  endfunction

  initial begin
    int rr_ch [6] = '{0, 1, 3, 0, 1, 3};
    int rr_p  [6] = '{1, 2, 0, 1, 2, 0};
    int w3_ch [4] = '{0, 1, 2, 0};
    int w3_p  [4] = '{1, 2, 0, 1};

    rst            = 1'b1;
    bus4.mode      = 1'b0;
    bus4.ctrl      = 2'd0;
    bus4.D         = {d4(3), d4(2), d4(1), d4(0)};
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    bus3.mode      = 1'b0;
    bus3.ctrl      = 2'd0;
    bus3.D         = {32'h0000_3002, 32'h0000_3001, 32'h0000_3000};
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;

    // Reset held two cycles with every channel valid.
    #1;
    chk("rst_ready_comb", 32'(bus4.in_ready), 32'h0);
    chk("rst_err_comb", 32'(bus4.sel_err), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_S", bus4.S, 32'h0);
      chk("rst_valid", 32'(bus4.out_valid), 32'h0);
      chk("rst_ch", 32'(bus4.out_ch), 32'h0);
      chk("rst_ready", 32'(bus4.in_ready), 32'h0);
      chk("rst_p", 32'(dut4.p), 32'h0);
    end
    chk("rst_valid3", 32'(bus3.out_valid), 32'h0);

    // Direct select of channel 2.
    rst           = 1'b0;
    bus4.ctrl     = 2'd2;
    bus4.in_valid = 4'b0100;
    #1;
    chk("dir_ready", 32'(bus4.in_ready), 32'h4);
    chk("dir_err", 32'(bus4.sel_err), 32'h0);
    tick();
    chk("dir_S", bus4.S, 32'hA5A5_0002);
    chk("dir_ch", 32'(bus4.out_ch), 32'h2);
    chk("dir_valid", 32'(bus4.out_valid), 32'h1);

    // Load 0x11 from channel 1, then stall with everything valid.
    bus4.ctrl     = 2'd1;
    bus4.in_valid = 4'b0010;
    #1;
    chk("ld11_ready", 32'(bus4.in_ready), 32'h2);
    tick();
    chk("ld11_S", bus4.S, 32'h11);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 32'(bus4.in_ready), 32'h0);
      tick();
      chk("bp_S", bus4.S, 32'h11);
      chk("bp_valid", 32'(bus4.out_valid), 32'h1);
      chk("bp_ch", 32'(bus4.out_ch), 32'h1);
    end

    // Release back-pressure while a new word is offered: no bubble.
    bus4.out_ready = 1'b1;
    bus4.ctrl      = 2'd3;
    #1;
    chk("rel_ready", 32'(bus4.in_ready), 32'h8);
    tick();
    chk("rel_S", bus4.S, 32'h33);
    chk("rel_valid", 32'(bus4.out_valid), 32'h1);
    chk("rel_ch", 32'(bus4.out_ch), 32'h3);

    // Drain with nothing offered: valid drops, data holds, pointer untouched.
    bus4.in_valid = 4'h0;
    #1;
    chk("drain_ready", 32'(bus4.in_ready), 32'h0);
    tick();
    chk("drain_valid", 32'(bus4.out_valid), 32'h0);
    chk("drain_S", bus4.S, 32'h33);
    chk("drain_ch", 32'(bus4.out_ch), 32'h3);
    chk("drain_p", 32'(dut4.p), 32'h0);

    // Round-robin over channels 0,1,3.
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", 32'(bus4.in_ready), 32'h1 << rr_ch[i]);
      tick();
      chk("rr_ch", 32'(bus4.out_ch), 32'(rr_ch[i]));
      chk("rr_S", bus4.S, d4(rr_ch[i]));
      chk("rr_valid", 32'(bus4.out_valid), 32'h1);
      chk("rr_p", 32'(dut4.p), 32'(rr_p[i]));
    end

    // Mode switch: RR grants ch1, two direct transfers from ch0, RR resumes at p=2.
    bus4.in_valid = 4'b0010;
    #1;
    chk("ms_rr_ready", 32'(bus4.in_ready), 32'h2);
    tick();
    chk("ms_rr_ch", 32'(bus4.out_ch), 32'h1);
    chk("ms_rr_p", 32'(dut4.p), 32'h2);
    bus4.mode     = 1'b0;
    bus4.ctrl     = 2'd0;
    bus4.in_valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("ms_dir_ready", 32'(bus4.in_ready), 32'h1);
      tick();
      chk("ms_dir_ch", 32'(bus4.out_ch), 32'h0);
      chk("ms_dir_p", 32'(dut4.p), 32'h2);
    end
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b0111;
    #1;
    chk("ms_back_ready", 32'(bus4.in_ready), 32'h4);
    tick();
    chk("ms_back_ch", 32'(bus4.out_ch), 32'h2);
    chk("ms_back_S", bus4.S, 32'hA5A5_0002);
    chk("ms_back_p", 32'(dut4.p), 32'h3);

    // Round-robin with nothing valid: no grant, no error, pointer holds.
    bus4.in_valid = 4'h0;
    #1;
    chk("rr_idle_ready", 32'(bus4.in_ready), 32'h0);
    chk("rr_idle_err", 32'(bus4.sel_err), 32'h0);
    tick();
    chk("rr_idle_p", 32'(dut4.p), 32'h3);
    chk("rr_idle_valid", 32'(bus4.out_valid), 32'h0);

    // Reset asserted while a transfer is offered discards it.
    bus4.in_valid = 4'hF;
    #1;
    chk("rm_pre_ready", 32'(bus4.in_ready), 32'h8);
    rst = 1'b1;
    #1;
    chk("rm_ready", 32'(bus4.in_ready), 32'h0);
    tick();
    chk("rm_valid", 32'(bus4.out_valid), 32'h0);
    chk("rm_S", bus4.S, 32'h0);
    chk("rm_p", 32'(dut4.p), 32'h0);
    rst = 1'b0;
    #1;
    chk("rm_post_ready", 32'(bus4.in_ready), 32'h1);
    tick();
    chk("rm_post_S", bus4.S, 32'hA5A5_0000);
    chk("rm_post_valid", 32'(bus4.out_valid), 32'h1);
    chk("rm_post_p", 32'(dut4.p), 32'h1);

    // Three-channel instance: out-of-range ctrl raises sel_err.
    bus4.in_valid = 4'h0;
    bus3.ctrl     = 2'd1;
    bus3.in_valid = 3'b111;
    #1;
    chk("n3_ready", 32'(bus3.in_ready), 32'h2);
    tick();
    chk("n3_S", bus3.S, 32'h3001);
    chk("n3_valid", 32'(bus3.out_valid), 32'h1);
    bus3.ctrl = 2'd3;
    #1;
    chk("err_pulse", 32'(bus3.sel_err), 32'h1);
    chk("err_ready", 32'(bus3.in_ready), 32'h0);
    tick();
    chk("err_valid", 32'(bus3.out_valid), 32'h0);
    chk("err_S", bus3.S, 32'h3001);
    bus3.ctrl = 2'd2;
    #1;
    chk("err_clear", 32'(bus3.sel_err), 32'h0);
    chk("n3_ch2_ready", 32'(bus3.in_ready), 32'h4);
    tick();
    chk("n3_ch2_S", bus3.S, 32'h3002);
    bus3.out_ready = 1'b0;
    bus3.ctrl      = 2'd3;
    #1;
    chk("err_blocked", 32'(bus3.sel_err), 32'h0);
    tick();
    chk("err_blocked_S", bus3.S, 32'h3002);

    // Three-channel round-robin wraps from 2 back to 0.
    bus3.out_ready = 1'b1;
    bus3.mode      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w3_ready", 32'(bus3.in_ready), 32'h1 << w3_ch[i]);
      tick();
      chk("w3_ch", 32'(bus3.out_ch), 32'(w3_ch[i]));
      chk("w3_p", 32'(dut3.p), 32'(w3_p[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
